// File: rtl/booth_mul_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// booth_mul_pkg : shared types and helpers for the radix-4 Booth multiplier
// Revision 1.0
// ---------------------------------------------------------------------------
package booth_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_t;

  // One extra step covers the two extension bits added to the multiplier.
  function automatic int calc_n_iter(input int width);
    return width / 2 + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_r4_enc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// booth_r4_enc : maps a 3-bit multiplier window to a radix-4 Booth digit
// Revision 1.0
// ---------------------------------------------------------------------------
module booth_r4_enc
  import booth_mul_pkg::*;
(
  input  logic [2:0]   i_window,
  output booth_digit_t o_digit
);

  always_comb begin
    o_digit = ZERO;
    case (i_window)
      3'b001, 3'b010: o_digit = POS1;
      3'b011:         o_digit = POS2;
      3'b100:         o_digit = NEG2;
      3'b101, 3'b110: o_digit = NEG1;
      default:        o_digit = ZERO;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/booth_seq_mul.sv
`default_nettype none
// ---------------------------------------------------------------------------
// booth_seq_mul : sequential radix-4 Booth multiplier, one step per enabled edge
// BOOTH_UNSIGNED_EN adds the sgn port (signed/unsigned select). Revision 1.0
// ---------------------------------------------------------------------------
module booth_seq_mul
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef BOOTH_UNSIGNED_EN
  input  logic               sgn,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int N_ITER = calc_n_iter(WIDTH);
  localparam int EXT_W  = WIDTH + 2;
  localparam int ACC_W  = 2 * WIDTH + 4;
  localparam int CNT_W  = $clog2(N_ITER + 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    r_mcand;
  logic [EXT_W-1:0]    r_mplr;
  logic                r_prev;
  logic [2*WIDTH-1:0]  r_result;

  logic                w_sgn;
  logic                w_accept;
  logic                w_last;
  logic [EXT_W-1:0]    w_a_ext;
  logic [EXT_W-1:0]    w_b_ext;
  booth_digit_t        w_digit;
  logic [ACC_W-1:0]    w_addend;
  logic [ACC_W-1:0]    w_acc_nxt;

`ifdef BOOTH_UNSIGNED_EN
  assign w_sgn = sgn;
`else
  assign w_sgn = 1'b1;
`endif

  assign in_ready  = (r_state == IDLE) && en;
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign result    = r_result;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == CNT_W'(N_ITER - 1));
  assign w_a_ext  = w_sgn ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
  assign w_b_ext  = w_sgn ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

  // Window is {b[2i+1], b[2i], b[2i-1]}; the multiplier shifts right so bits 1:0 are current.
  booth_r4_enc u_enc (
    .i_window ({r_mplr[1:0], r_prev}),
    .o_digit  (w_digit)
  );

  always_comb begin
    w_addend = '0;
    case (w_digit)
      POS1:    w_addend = r_mcand;
      POS2:    w_addend = r_mcand << 1;
      NEG1:    w_addend = -r_mcand;
      NEG2:    w_addend = -(r_mcand << 1);
      default: w_addend = '0;
    endcase
  end

  assign w_acc_nxt = r_acc + w_addend;

  always_comb begin
    w_state_nxt = r_state;
    if (en) begin
      case (r_state)
        IDLE:    if (w_accept) w_state_nxt = CALC;
        CALC:    if (w_last) w_state_nxt = DONE;
        DONE:    if (out_ready) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplr   <= '0;
      r_prev   <= 1'b0;
      r_result <= '0;
    end else if (en) begin
      if (w_accept) begin
        r_cnt   <= '0;
        r_acc   <= '0;
        r_mcand <= {{(ACC_W-EXT_W){w_a_ext[EXT_W-1]}}, w_a_ext};
        r_mplr  <= w_b_ext;
        r_prev  <= 1'b0;
      end else if (r_state == CALC) begin
        r_acc   <= w_acc_nxt;
        r_mcand <= r_mcand << 2;
        r_mplr  <= r_mplr >> 2;
        r_prev  <= r_mplr[1];
        if (w_last) begin
          r_cnt    <= '0;
          r_result <= w_acc_nxt[2*WIDTH-1:0];
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_booth_seq_mul.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_booth_seq_mul : directed self-checking bench for booth_seq_mul (WIDTH=32)
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_booth_seq_mul;

  logic        clk;
  logic        reset;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        sgn;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  booth_seq_mul #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
`ifdef BOOTH_UNSIGNED_EN
    .sgn       (sgn),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Accept, optionally stall 5 cycles after 5 steps, wait for out_valid, check, pop.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        input logic [63:0] exp, input int stall, input string tag);
    int lat;
    lat = 0;
    out_ready = 1'b1;
    a_i = av;
    b_i = bv;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    a_i = $urandom;
    b_i = $urandom;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    if (stall > 0) begin
      for (int k = 0; k < 5; k++) begin
        tick();
        lat++;
      end
      en = 1'b0;
      for (int k = 0; k < stall; k++) begin
        tick();
        lat++;
        chk({tag, "_frozen_valid"}, 64'(out_valid), 64'd0);
      end
      en = 1'b1;
    end
    for (int k = 0; k < 100; k++) begin
      tick();
      lat++;
      if (out_valid) break;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(17 + stall));
    chk({tag, "_result"}, result, exp);
    tick();
    chk({tag, "_popped"}, 64'(out_valid), 64'd0);
    chk({tag, "_ready_after"}, 64'(in_ready), 64'd1);
    chk({tag, "_result_kept"}, result, exp);
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  cnt;
    logic seen_valid;
    reset = 1'b1;
    en = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a_i = '0;
    b_i = '0;
    sgn = 1'b1;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", result, 64'd0);
    en = 1'b0;
    #1;
    chk("rst_in_ready_en0", 64'(in_ready), 64'd0);
    en = 1'b1;
    reset = 1'b0;
    tick();

    run_op(32'd5, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFDD, 0, "5x-7");
    run_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, "min_x_min");
    run_op(32'hFFFF_FFF4, 32'hFFFF_FFFC, 64'd48, 0, "-12x-4");
    run_op(32'd11, 32'd0, 64'd0, 0, "11x0");
    run_op(32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 0, "max_x_min");

    // Back-pressure: result held in DONE, in_valid ignored.
    a_i = 32'd4;
    b_i = 32'd6;
    in_valid = 1'b1;
    tick();
    a_i = 32'd99;
    b_i = 32'd77;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      cnt++;
      if (out_valid) break;
    end
    chk("hold_latency", 64'(cnt), 64'd17);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("hold_result", result, 64'd24);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    chk("hold_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("hold_pop", 64'(out_valid), 64'd0);
    chk("hold_idle", 64'(busy), 64'd0);
    out_ready = 1'b0;

    // Reset mid-calculation discards the operation.
    a_i = 32'hFFFF_FFF7;
    b_i = 32'd5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    reset = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", result, 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    tick();
    #2;
    reset = 1'b0;
    seen_valid = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (out_valid) seen_valid = 1'b1;
    end
    chk("midrst_no_valid", 64'(seen_valid), 64'd0);
    chk("midrst_idle", 64'(busy), 64'd0);
    run_op(32'd2, 32'd3, 64'd6, 0, "2x3");

    run_op(32'd10, 32'd1, 64'd10, 5, "en_stall");

`ifdef BOOTH_UNSIGNED_EN
    sgn = 1'b0;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, "unsigned_ff");
    sgn = 1'b1;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 0, "signed_ff");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/booth_seq_mul.md
BOOTH_SEQ_MUL -- requirements
Module: booth_seq_mul

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width in bits; even, >= 4.
REQ-002 SHALL have derived localparam: N_ITER, WIDTH/2+1, radix-4 steps per product.
REQ-003 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port: en  in  1  clock enable; when 0, all state holds and no handshake completes.
REQ-006 SHALL have port: in_valid  in  1  operands present.
REQ-007 SHALL have port: in_ready  out  1  block accepts operands.
REQ-008 SHALL have port: a  in  WIDTH  multiplicand.
REQ-009 SHALL have port: b  in  WIDTH  multiplier.
REQ-010 SHALL have port: sgn  in  1  1 = signed operands, 0 = unsigned; present only with BOOTH_UNSIGNED_EN.
REQ-011 SHALL have port: out_valid  out  1  result available.
REQ-012 SHALL have port: out_ready  in  1  consumer takes result.
REQ-013 SHALL have port: result  out  2*WIDTH  product, two's complement when signed.
REQ-014 SHALL have port: busy  out  1  high in CALC or DONE.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE.
REQ-016 SHALL drive in_ready = (state==IDLE) && en; acceptance is in_valid && in_ready at a rising edge.
REQ-017 On acceptance SHALL capture a, b (and sgn) into internal registers, extend both to WIDTH+2 bits (sign-extend if signed, zero-extend if unsigned), clear accumulator, enter CALC with step counter 0.
REQ-018 In CALC, each enabled edge SHALL perform one radix-4 Booth step: decode multiplier bits {b[2i+1], b[2i], b[2i-1]} (b[-1]=0) into digit in {0, +-1, +-2}, add digit*A into accumulator, advance by two bit positions.
REQ-019 Accumulator width SHALL be sufficient for exact products; result SHALL equal exact a*b truncated to 2*WIDTH bits, which is exact for all inputs including (-2^(W-1))*(-2^(W-1)) = 2^(2W-2).
REQ-020 After the N_ITER-th step edge SHALL enter DONE; with en held 1, out_valid rises exactly N_ITER edges after the accepting edge (17 for WIDTH=32).
REQ-021 In DONE, out_valid=1 and result SHALL hold stable until out_valid && out_ready && en at an edge, then go to IDLE; in_ready rises the following cycle (no same-cycle re-accept).
REQ-022 result SHALL keep the last product in IDLE until the next product completes; operand port changes after acceptance SHALL not affect the product.
REQ-023 en=0 in any state SHALL freeze state, counter, accumulator and outputs; latency counts enabled edges only.
REQ-024 in_valid during CALC/DONE SHALL be ignored (in_ready=0); no queueing.

Reset
REQ-025 reset=1 SHALL asynchronously force IDLE, counter 0, accumulator 0, result 0, out_valid 0, busy 0; in_ready = en.
REQ-026 reset mid-CALC or in DONE SHALL discard the operation; no out_valid for it after release.

Configuration
REQ-027 Macro BOOTH_UNSIGNED_EN defined: sgn port exists and selects extension per REQ-017.
REQ-028 Macro BOOTH_UNSIGNED_EN undefined: no sgn port, operands always signed; latency unchanged (N_ITER).

Structure
REQ-029 Package booth_mul_pkg SHALL hold the FSM state enum, the Booth digit typedef (ZERO, POS1, POS2, NEG1, NEG2) and a function computing N_ITER from WIDTH.
REQ-030 Sub-module booth_r4_enc SHALL map a 3-bit multiplier window to a Booth digit, purely combinational.

Verification
REQ-031 WIDTH=32, a=5, b=-7, out_ready=1 -> out_valid 17 edges after accept, result=-35, then in_ready=1 next cycle.
REQ-032 a=-2^31, b=-2^31 -> result=2^62; a=-12, b=-4 -> 48; a=11, b=0 -> 0.
REQ-033 a=4, b=6, out_ready=0 for 10 cycles after out_valid -> result 24 held, in_ready=0 throughout, pop on first out_ready=1 edge.
REQ-034 Accept a=-9, b=5, assert reset at step 8 -> out_valid=0, result=0, IDLE; next op a=2, b=3 -> 6.
REQ-035 a=10, b=1, en=0 for 5 cycles mid-CALC -> out_valid at 17+5 edges, result=10.
REQ-036 With BOOTH_UNSIGNED_EN, sgn=0, a=b=0xFFFFFFFF -> result=0xFFFFFFFE00000001; sgn=1 same operands -> result=1.
